vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 230 +++++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose:
//   Generic VGA-style raster timing generator with a built-in pixel-rate
//   divider. A divider running on CLK_IN produces a one-cycle pixel-step
//   strobe (PXL_EN). Each strobe advances a horizontal counter, which in turn
//   advances a vertical counter at the end of each line. The current counter
//   position is decoded into an active-video request with coordinates, and
//   into registered video outputs (syncs, DE, RGB). These outputs lag the
//   counter position by exactly one pixel step.
//
// Ports:
//   CLK_IN       in   1        single system clock (all logic on this edge)
//   RST_IN       in   1        synchronous active-high reset
//   EN           in   1        timing run enable; 0 freezes divider/counters
//   RGB_IN       in   COLOR_W  pixel data for the coordinate presented on the
//                              previous pixel step (sampled on PXL_EN only)
//   PXL_EN       out  1        pixel-step strobe, one CLK_IN cycle wide
//   X_COORD      out  CNT_W    active x coordinate (0 outside active video)
//   Y_COORD      out  CNT_W    active y coordinate (0 outside active video)
//   PIX_REQ      out  1        current counter position is in active video
//   H_SYNC       out  1        registered horizontal sync (HS_POL = active)
//   V_SYNC       out  1        registered vertical sync (VS_POL = active)
//   DE           out  1        registered data enable
//   RGB          out  COLOR_W  registered pixel data (0 while blanked)
//   FRAME_START  out  1        pixel step at position (0,0)
//   LINE_START   out  1        pixel step at h position 0
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int   H_DISP  = 640,
  parameter int   H_FRONT = 16,
  parameter int   H_PULSE = 96,
  parameter int   H_BACK  = 48,
  parameter int   V_DISP  = 480,
  parameter int   V_FRONT = 10,
  parameter int   V_PULSE = 2,
  parameter int   V_BACK  = 29,
  parameter logic HS_POL  = 1'b0,
  parameter logic VS_POL  = 1'b0,
  parameter int   CLK_DIV = 2,
  parameter int   COLOR_W = 8,
  parameter int   CNT_W   = 12
) (
  input  logic               CLK_IN,
  input  logic               RST_IN,
  input  logic               EN,
  input  logic [COLOR_W-1:0] RGB_IN,
  output logic               PXL_EN,
  output logic [CNT_W-1:0]   X_COORD,
  output logic [CNT_W-1:0]   Y_COORD,
  output logic               PIX_REQ,
  output logic               H_SYNC,
  output logic               V_SYNC,
  output logic               DE,
  output logic [COLOR_W-1:0] RGB,
  output logic               FRAME_START,
  output logic               LINE_START
);

  // -------------------------------------------------------------------------
  // Derived constants
  // -------------------------------------------------------------------------
  localparam int H_TOTAL = H_DISP + H_FRONT + H_PULSE + H_BACK;
  localparam int V_TOTAL = V_DISP + V_FRONT + V_PULSE + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Region boundaries are compared one bit wider than the counters so that a
  // region ending exactly at 2**CNT_W (zero back porch, full-width total)
  // does not wrap to zero.
  localparam int XW = CNT_W + 1;
  localparam logic [XW-1:0] H_DISP_X  = XW'(H_DISP);
  localparam logic [XW-1:0] H_SYNC_SX = XW'(H_DISP + H_FRONT);
  localparam logic [XW-1:0] H_SYNC_EX = XW'(H_DISP + H_FRONT + H_PULSE);
  localparam logic [XW-1:0] V_DISP_X  = XW'(V_DISP);
  localparam logic [XW-1:0] V_SYNC_SX = XW'(V_DISP + V_FRONT);
  localparam logic [XW-1:0] V_SYNC_EX = XW'(V_DISP + V_FRONT + V_PULSE);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // -------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // -------------------------------------------------------------------------
  if (H_TOTAL > (64'd1 << CNT_W)) begin : g_h_total_overflow
    $error("vga_timing_gen: H_TOTAL (%0d) does not fit in CNT_W=%0d bits",
           H_TOTAL, CNT_W);
  end

  if (V_TOTAL > (64'd1 << CNT_W)) begin : g_v_total_overflow
    $error("vga_timing_gen: V_TOTAL (%0d) does not fit in CNT_W=%0d bits",
           V_TOTAL, CNT_W);
  end

  if ((CLK_DIV < 1) || (CLK_DIV > 16)) begin : g_clk_div_range
    $error("vga_timing_gen: CLK_DIV=%0d outside legal range 1..16", CLK_DIV);
  end

  if ((H_TOTAL < 1) || (V_TOTAL < 1)) begin : g_total_empty
    $error("vga_timing_gen: line or frame total is zero");
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [DIV_W-1:0]   div_q,   div_d;
  logic [CNT_W-1:0]   h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0]   v_cnt_q, v_cnt_d;
  logic               de_q,    de_d;
  logic [COLOR_W-1:0] rgb_q,   rgb_d;
  logic               hs_q,    hs_d;
  logic               vs_q,    vs_d;

  // -------------------------------------------------------------------------
  // Position decode (combinational on the current counter values)
  // -------------------------------------------------------------------------
  logic [XW-1:0] h_ext;
  logic [XW-1:0] v_ext;
  logic          h_active;
  logic          v_active;
  logic          h_in_sync;
  logic          v_in_sync;
  logic          div_at_last;
  logic          pxl_en;
  logic          pix_req;
  logic          line_start;

  assign h_ext = {1'b0, h_cnt_q};
  assign v_ext = {1'b0, v_cnt_q};

  assign h_active  = (h_ext < H_DISP_X);
  assign v_active  = (v_ext < V_DISP_X);
  assign h_in_sync = (h_ext >= H_SYNC_SX) && (h_ext < H_SYNC_EX);
  assign v_in_sync = (v_ext >= V_SYNC_SX) && (v_ext < V_SYNC_EX);

  assign div_at_last = (div_q == DIV_LAST);

  // The strobe is masked while reset is held: with CLK_DIV=1 the divider
  // sits permanently at its last value, so without the mask a held reset
  // would still show pixel steps and start pulses.
  assign pxl_en  = EN && !RST_IN && div_at_last;
  assign pix_req = h_active && v_active && EN;

  assign line_start = pxl_en && (h_cnt_q == '0);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    div_d   = div_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;

    // Divider only advances while enabled; when EN drops it keeps its phase
    // so a resumed run continues the partially elapsed pixel period.
    if (EN) begin
      div_d = div_at_last ? '0 : (div_q + DIV_W'(1));
    end

    if (pxl_en) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : (v_cnt_q + CNT_W'(1));
      end else begin
        h_cnt_d = h_cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    de_d  = de_q;
    rgb_d = rgb_q;
    hs_d  = hs_q;
    vs_d  = vs_q;

    if (!EN) begin
      // Disabled: blank the video outputs on the next edge.
      de_d  = 1'b0;
      rgb_d = '0;
      hs_d  = ~HS_POL;
      vs_d  = ~VS_POL;
    end else if (pxl_en) begin
      // All registered outputs are captured from the same counter position,
      // so they stay mutually aligned one pixel step behind the counters.
      de_d  = pix_req;
      rgb_d = pix_req ? RGB_IN : '0;
      hs_d  = h_in_sync ? HS_POL : ~HS_POL;
      vs_d  = v_in_sync ? VS_POL : ~VS_POL;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      div_q   <= '0;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      de_q    <= 1'b0;
      rgb_q   <= '0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
    end else begin
      div_q   <= div_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      de_q    <= de_d;
      rgb_q   <= rgb_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign PXL_EN      = pxl_en;
  assign PIX_REQ     = pix_req;
  assign X_COORD     = pix_req ? h_cnt_q : '0;
  assign Y_COORD     = pix_req ? v_cnt_q : '0;
  assign LINE_START  = line_start;
  assign FRAME_START = line_start && (v_cnt_q == '0);
  assign H_SYNC      = hs_q;
  assign V_SYNC      = vs_q;
  assign DE          = de_q;
  assign RGB         = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Four generator instances with different geometries, dividers and sync
// polarities share one clock, reset, enable and random pixel data. A
// reference model describes each instance purely in terms of "number of
// enabled clock cycles since reset": pixel steps are every CLK_DIV-th such
// cycle, and the raster position is the step count folded modulo the line
// and frame totals. Every output of every instance is compared against that
// model once per clock cycle, on the falling edge.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int NI = 4;

  // Instance geometry: 0 = small/div2, 1 = small/div3/active-high syncs,
  // 2 = small/div1/mixed polarity, 3 = module defaults (640x480).
  localparam int P_HD  [NI] = '{10, 8, 12, 640};
  localparam int P_HF  [NI] = '{3,  2, 1,  16};
  localparam int P_HP  [NI] = '{4,  3, 2,  96};
  localparam int P_HB  [NI] = '{5,  4, 3,  48};
  localparam int P_VD  [NI] = '{6,  5, 4,  480};
  localparam int P_VF  [NI] = '{2,  1, 2,  10};
  localparam int P_VP  [NI] = '{2,  2, 1,  2};
  localparam int P_VB  [NI] = '{3,  2, 1,  29};
  localparam int P_DIV [NI] = '{2,  3, 1,  2};
  localparam int P_HSP [NI] = '{0,  1, 1,  0};
  localparam int P_VSP [NI] = '{0,  1, 0,  0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic [7:0] rgb_in = 8'h00;

  logic [NI-1:0] pxl_w, pix_w, hs_w, vs_w, de_w, fs_w, ls_w;
  logic [11:0]   x_w   [NI];
  logic [11:0]   y_w   [NI];
  logic [7:0]    rgb_w [NI];

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_DISP(10), .H_FRONT(3), .H_PULSE(4), .H_BACK(5),
    .V_DISP(6), .V_FRONT(2), .V_PULSE(2), .V_BACK(3),
    .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(2), .COLOR_W(8), .CNT_W(12)
  ) u_dut0 (
    .CLK_IN(clk), .RST_IN(rst), .EN(en), .RGB_IN(rgb_in),
    .PXL_EN(pxl_w[0]), .X_COORD(x_w[0]), .Y_COORD(y_w[0]), .PIX_REQ(pix_w[0]),
    .H_SYNC(hs_w[0]), .V_SYNC(vs_w[0]), .DE(de_w[0]), .RGB(rgb_w[0]),
    .FRAME_START(fs_w[0]), .LINE_START(ls_w[0])
  );

  vga_timing_gen #(
    .H_DISP(8), .H_FRONT(2), .H_PULSE(3), .H_BACK(4),
    .V_DISP(5), .V_FRONT(1), .V_PULSE(2), .V_BACK(2),
    .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(3), .COLOR_W(8), .CNT_W(12)
  ) u_dut1 (
    .CLK_IN(clk), .RST_IN(rst), .EN(en), .RGB_IN(rgb_in),
    .PXL_EN(pxl_w[1]), .X_COORD(x_w[1]), .Y_COORD(y_w[1]), .PIX_REQ(pix_w[1]),
    .H_SYNC(hs_w[1]), .V_SYNC(vs_w[1]), .DE(de_w[1]), .RGB(rgb_w[1]),
    .FRAME_START(fs_w[1]), .LINE_START(ls_w[1])
  );

  vga_timing_gen #(
    .H_DISP(12), .H_FRONT(1), .H_PULSE(2), .H_BACK(3),
    .V_DISP(4), .V_FRONT(2), .V_PULSE(1), .V_BACK(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .CLK_DIV(1), .COLOR_W(8), .CNT_W(12)
  ) u_dut2 (
    .CLK_IN(clk), .RST_IN(rst), .EN(en), .RGB_IN(rgb_in),
    .PXL_EN(pxl_w[2]), .X_COORD(x_w[2]), .Y_COORD(y_w[2]), .PIX_REQ(pix_w[2]),
    .H_SYNC(hs_w[2]), .V_SYNC(vs_w[2]), .DE(de_w[2]), .RGB(rgb_w[2]),
    .FRAME_START(fs_w[2]), .LINE_START(ls_w[2])
  );

  vga_timing_gen u_dut3 (
    .CLK_IN(clk), .RST_IN(rst), .EN(en), .RGB_IN(rgb_in),
    .PXL_EN(pxl_w[3]), .X_COORD(x_w[3]), .Y_COORD(y_w[3]), .PIX_REQ(pix_w[3]),
    .H_SYNC(hs_w[3]), .V_SYNC(vs_w[3]), .DE(de_w[3]), .RGB(rgb_w[3]),
    .FRAME_START(fs_w[3]), .LINE_START(ls_w[3])
  );

  // -------------------------------------------------------------------------
  // Checking
  // -------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  int cur_inst = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t got=%0h expected=%0h",
               tag, cur_inst, $time, got, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  int         m_en_cnt [NI];   // enabled, non-reset cycles since reset
  logic       m_de     [NI];
  logic [7:0] m_rgb    [NI];
  logic       m_hs     [NI];
  logic       m_vs     [NI];
  bit         armed = 1'b0;

  function automatic int h_tot(input int k);
    return P_HD[k] + P_HF[k] + P_HP[k] + P_HB[k];
  endfunction

  function automatic int v_tot(input int k);
    return P_VD[k] + P_VF[k] + P_VP[k] + P_VB[k];
  endfunction

  function automatic int pos_h(input int k);
    return (m_en_cnt[k] / P_DIV[k]) % h_tot(k);
  endfunction

  function automatic int pos_v(input int k);
    return ((m_en_cnt[k] / P_DIV[k]) / h_tot(k)) % v_tot(k);
  endfunction

  function automatic logic model_pxl(input int k);
    return en && !rst && ((m_en_cnt[k] % P_DIV[k]) == P_DIV[k] - 1);
  endfunction

  // Inputs change 2 time units after a rising edge, so at the falling edge
  // they hold the values the next rising edge will sample: check the present
  // state first, then advance the model across that coming edge.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      int   h;
      int   v;
      logic act;
      logic pxl;
      logic hsync_now;
      logic vsync_now;
      h   = pos_h(k);
      v   = pos_v(k);
      act = (h < P_HD[k]) && (v < P_VD[k]) && en;
      pxl = model_pxl(k);
      cur_inst = k;
      if (armed) begin
        check_val("pxl_en",      32'(pxl_w[k]), 32'(pxl));
        check_val("line_start",  32'(ls_w[k]),  32'(pxl && h == 0));
        check_val("frame_start", 32'(fs_w[k]),  32'(pxl && h == 0 && v == 0));
        check_val("pix_req",     32'(pix_w[k]), 32'(act));
        check_val("x_coord",     32'(x_w[k]),   act ? 32'(h) : 32'd0);
        check_val("y_coord",     32'(y_w[k]),   act ? 32'(v) : 32'd0);
        check_val("de",          32'(de_w[k]),  32'(m_de[k]));
        check_val("rgb",         32'(rgb_w[k]), 32'(m_rgb[k]));
        check_val("h_sync",      32'(hs_w[k]),  32'(m_hs[k]));
        check_val("v_sync",      32'(vs_w[k]),  32'(m_vs[k]));
      end

      hsync_now = (h >= P_HD[k] + P_HF[k]) && (h < P_HD[k] + P_HF[k] + P_HP[k]);
      vsync_now = (v >= P_VD[k] + P_VF[k]) && (v < P_VD[k] + P_VF[k] + P_VP[k]);
      if (rst || !en) begin
        if (rst) m_en_cnt[k] = 0;
        m_de[k]  = 1'b0;
        m_rgb[k] = 8'h00;
        m_hs[k]  = (P_HSP[k] == 0);
        m_vs[k]  = (P_VSP[k] == 0);
      end else begin
        if (pxl) begin
          m_de[k]  = act;
          m_rgb[k] = act ? rgb_in : 8'h00;
          m_hs[k]  = hsync_now ? (P_HSP[k] != 0) : (P_HSP[k] == 0);
          m_vs[k]  = vsync_now ? (P_VSP[k] != 0) : (P_VSP[k] == 0);
        end
        m_en_cnt[k]++;
      end
    end
    if (rst) armed = 1'b1;
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int en_hold;
    int reached;

    // Reset held for three edges with EN high, then released.
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Free run: covers several full frames of the small instances.
    for (int i = 0; i < 1800; i++) begin
      rgb_in = 8'($urandom);
      tick();
    end

    // EN dropped for 50 cycles at a known mid-line position of instance 0.
    reached = 0;
    for (int i = 0; i < 200 && reached == 0; i++) begin
      if (pos_h(0) == 5 && pos_v(0) == 2) reached = 1;
      else tick();
    end
    cur_inst = 0;
    check_val("reach_pos", 32'(reached), 32'd1);
    en = 1'b0;
    repeat (50) tick();
    en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rgb_in = 8'($urandom);
      tick();
    end

    // Reset pulsed mid-frame, both with EN low and with EN high.
    en  = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    en  = 1'b1;
    for (int i = 0; i < 400; i++) begin
      rgb_in = 8'($urandom);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Randomized enable bursts and occasional resets.
    en_hold = 0;
    for (int i = 0; i < 6000; i++) begin
      rgb_in = 8'($urandom);
      if (en_hold > 0) begin
        en_hold--;
        en = 1'b0;
      end else begin
        en = 1'b1;
        if ($urandom_range(0, 99) == 0) en_hold = $urandom_range(1, 40);
      end
      rst = ($urandom_range(0, 999) == 0);
      tick();
    end

    rst = 1'b0;
    en  = 1'b1;
    repeat (20) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
